// File: rtl/md_issue_if.sv
// E-stage <-> multiply-divide issue bundle: pipeline-side inputs, unit Busy, and the controller's
// issue/stall/status outputs.
interface md_issue_if #(
    parameter int unsigned CNT_W = 32
);
    logic [2:0]       op_E;
    logic             valid_E;
    logic             adv_E;
    logic             ExcReq_E;
    logic             EI_HILO_ctr;
    logic             hilo_use_D;
    logic             Busy;
    logic             Start;
    logic [2:0]       Mul_Div_ctr;
    logic             Stall_MD;
    logic             lat_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output op_E, valid_E, adv_E, ExcReq_E, EI_HILO_ctr, hilo_use_D, Busy,
        input  Start, Mul_Div_ctr, Stall_MD, lat_err, stall_cnt
    );

    modport slave (
        input  op_E, valid_E, adv_E, ExcReq_E, EI_HILO_ctr, hilo_use_D, Busy,
        output Start, Mul_Div_ctr, Stall_MD, lat_err, stall_cnt
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// Issue/hazard controller in front of the HI/LO multiply-divide unit: one Start per E-stage
// instruction, D-stage stall while HI/LO is in flight, Busy-window latency check, stall counter.
module md_issue_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 9,
    parameter int unsigned CNT_W   = 32
) (
    input  logic        clk,
    input  logic        reset,
    md_issue_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StWaitBusy, StRun} state_e;

    state_e           state_q, state_d;
    logic             issued_q, issued_d;
    logic [3:0]       lat_cnt_q, lat_cnt_d;
    logic [3:0]       exp_lat_q, exp_lat_d;
    logic             lat_err_q, lat_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             busy_ign_q, busy_ign_d;

    logic is_md, is_mul, busy_eff, start, stall;

    assign is_md  = (bus.op_E == 3'b011) || (bus.op_E == 3'b100) ||
                    (bus.op_E == 3'b101) || (bus.op_E == 3'b110);
    assign is_mul = (bus.op_E == 3'b011) || (bus.op_E == 3'b100);
    // After a reset the unit may still be finishing an old op; its Busy is not ours to stall on.
    assign busy_eff = bus.Busy & ~busy_ign_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        exp_lat_d = exp_lat_q;
        lat_err_d = lat_err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StWaitBusy;
                    lat_cnt_d = 4'd0;
                    exp_lat_d = is_mul ? 4'(MUL_LAT) : 4'(DIV_LAT);
                end
            end
            StWaitBusy: begin
                if (bus.Busy) begin
                    state_d   = StRun;
                    lat_cnt_d = 4'd1;
                end else begin
                    state_d   = StIdle;
                    lat_err_d = 1'b1;
                end
            end
            StRun: begin
                if (!bus.Busy) begin
                    state_d = StIdle;
                    if (lat_cnt_q != exp_lat_q) lat_err_d = 1'b1;
                end else if (lat_cnt_q == 4'd15) begin
                    state_d   = StIdle;
                    lat_err_d = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs. RUN with Busy low is the completion cycle: HI/LO is already valid, so no stall.
    always_comb begin
        start = reset & bus.valid_E & is_md & ~issued_q & ~bus.ExcReq_E & ~bus.EI_HILO_ctr &
                (state_q == StIdle) & ~bus.Busy;
        stall = reset & bus.hilo_use_D & (start | busy_eff | (state_q == StWaitBusy));
    end

    always_comb begin
        issued_d = issued_q;
        if (bus.adv_E)  issued_d = 1'b0;
        else if (start) issued_d = 1'b1;

        busy_ign_d = busy_ign_q & bus.Busy;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            issued_q    <= 1'b0;
            lat_cnt_q   <= 4'd0;
            exp_lat_q   <= 4'd0;
            lat_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            busy_ign_q  <= 1'b1;
        end else begin
            issued_q    <= issued_d;
            lat_cnt_q   <= lat_cnt_d;
            exp_lat_q   <= exp_lat_d;
            lat_err_q   <= lat_err_d;
            stall_cnt_q <= stall_cnt_d;
            busy_ign_q  <= busy_ign_d;
        end
    end

    assign bus.Start       = start;
    assign bus.Stall_MD    = stall;
    assign bus.Mul_Div_ctr = bus.valid_E ? bus.op_E : 3'b000;
    assign bus.lat_err     = lat_err_q;
    assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a simple behavioural multiply-divide unit providing Busy.
module tb_md_issue_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass = 0;
    int   model_lat = 4;
    int   busy_rem = 0;
    int   starts;

    always #5 clk = ~clk;

    md_issue_if #(.CNT_W(32)) bus ();

    md_issue_ctrl #(.MUL_LAT(4), .DIV_LAT(9), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Unit model: Busy high for model_lat cycles after the edge that samples Start.
    always @(posedge clk) begin
        if (!reset)         busy_rem <= 0;
        else if (bus.Start) busy_rem <= model_lat;
        else if (busy_rem != 0) busy_rem <= busy_rem - 1;
    end
    assign bus.Busy = (busy_rem != 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [2:0] op, input logic v, input logic adv, input logic hu);
        bus.op_E       = op;
        bus.valid_E    = v;
        bus.adv_E      = adv;
        bus.hilo_use_D = hu;
    endtask

    initial begin
        reset = 1'b0;
        bus.ExcReq_E = 1'b0;
        bus.EI_HILO_ctr = 1'b0;
        drive(3'b100, 1'b1, 1'b0, 1'b1);
        #1;
        check("rst_start", {31'd0, bus.Start}, 0);
        check("rst_stall", {31'd0, bus.Stall_MD}, 0);
        tick(); tick();
        check("rst_lat_err", {31'd0, bus.lat_err}, 0);
        check("rst_stall_cnt", bus.stall_cnt, 0);
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick();

        // 1: mult advancing immediately
        model_lat = 4;
        drive(3'b100, 1'b1, 1'b1, 1'b0);
        #1;
        check("t1_start", {31'd0, bus.Start}, 1);
        check("t1_ctr", {29'd0, bus.Mul_Div_ctr}, 4);
        tick();
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        #1;
        check("t1_ctr_bubble", {29'd0, bus.Mul_Div_ctr}, 0);
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.Start) starts++;
            tick();
        end
        check("t1_extra_starts", starts, 0);
        check("t1_lat_err", {31'd0, bus.lat_err}, 0);
        bus.hilo_use_D = 1'b1;
        #1;
        check("t1_idle_probe", {31'd0, bus.Stall_MD}, 0);
        bus.hilo_use_D = 1'b0;
        tick();

        // 2: div held 12 cycles, advances on the last one
        model_lat = 9;
        starts = 0;
        for (int i = 0; i < 12; i++) begin
            drive(3'b110, 1'b1, (i == 11), 1'b0);
            #1;
            if (bus.Start) starts++;
            tick();
        end
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        check("t2_one_start", starts, 1);
        tick(); tick();
        check("t2_lat_err", {31'd0, bus.lat_err}, 0);

        // 3: multu with mflo waiting in D
        model_lat = 4;
        drive(3'b011, 1'b1, 1'b1, 1'b1);
        #1;
        check("t3_start", {31'd0, bus.Start}, 1);
        check("t3_stall_c0", {31'd0, bus.Stall_MD}, 1);
        check("t3_ctr", {29'd0, bus.Mul_Div_ctr}, 3);
        tick();
        drive(3'b000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t3_stall_c%0d", i + 1), {31'd0, bus.Stall_MD}, (i < 4) ? 1 : 0);
            tick();
        end
        bus.hilo_use_D = 1'b0;
        #1;
        check("t3_stall_cnt", bus.stall_cnt, 5);
        check("t3_lat_err", {31'd0, bus.lat_err}, 0);
        tick();

        // 4: div blocked by ExcReq_E, then by EI_HILO_ctr
        model_lat = 9;
        drive(3'b110, 1'b1, 1'b0, 1'b1);
        bus.ExcReq_E = 1'b1;
        #1;
        check("t4_exc_start", {31'd0, bus.Start}, 0);
        check("t4_exc_stall", {31'd0, bus.Stall_MD}, 0);
        tick();
        #1;
        check("t4_exc_stall_held", {31'd0, bus.Stall_MD}, 0);
        bus.ExcReq_E = 1'b0;
        bus.EI_HILO_ctr = 1'b1;
        #1;
        check("t4_ei_start", {31'd0, bus.Start}, 0);
        check("t4_ei_stall", {31'd0, bus.Stall_MD}, 0);
        tick();
        #1;
        check("t4_ei_stall_held", {31'd0, bus.Stall_MD}, 0);
        // issued must still be clear, so the held div now issues
        bus.EI_HILO_ctr = 1'b0;
        bus.hilo_use_D = 1'b0;
        #1;
        check("t4_issue_after", {31'd0, bus.Start}, 1);
        tick();
        drive(3'b110, 1'b1, 1'b1, 1'b0);
        tick();
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) tick();
        check("t4_stall_cnt", bus.stall_cnt, 5);
        check("t4_lat_err", {31'd0, bus.lat_err}, 0);

        // 5: unit holds Busy 6 cycles on a mult
        model_lat = 6;
        drive(3'b100, 1'b1, 1'b1, 1'b0);
        #1;
        check("t5_start", {31'd0, bus.Start}, 1);
        tick();
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("t5_err_not_yet", {31'd0, bus.lat_err}, 0);
        for (int i = 0; i < 3; i++) tick();
        check("t5_err_set", {31'd0, bus.lat_err}, 1);
        for (int i = 0; i < 5; i++) tick();
        check("t5_err_sticky", {31'd0, bus.lat_err}, 1);

        // 6: reset in the middle of a div
        model_lat = 9;
        drive(3'b110, 1'b1, 1'b1, 1'b0);
        #1;
        check("t6_start", {31'd0, bus.Start}, 1);
        tick();
        drive(3'b000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b0;
        #1;
        check("t6_rst_stall", {31'd0, bus.Stall_MD}, 0);
        tick(); tick();
        reset = 1'b1;
        #1;
        check("t6_post_lat_err", {31'd0, bus.lat_err}, 0);
        check("t6_post_stall_cnt", bus.stall_cnt, 0);
        check("t6_post_stall", {31'd0, bus.Stall_MD}, 0);
        check("t6_post_start", {31'd0, bus.Start}, 0);
        bus.hilo_use_D = 1'b0;
        tick();
        model_lat = 4;
        drive(3'b100, 1'b1, 1'b1, 1'b0);
        #1;
        check("t6_new_start", {31'd0, bus.Start}, 1);
        tick();
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        check("t6_new_lat_err", {31'd0, bus.lat_err}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
